// File: rtl/acc_pkg.sv
// Shared constants and types for the conv accelerator APB front end.
package acc_pkg;

    localparam int ADDR_W    = 13;
    localparam int A_WORDS   = 3;
    localparam int X_WORDS   = 196;
    localparam int RES_DEPTH = 784;
    localparam int RES_W     = 20;

    localparam logic [ADDR_W-1:0] ACC_EN_ADDR     = 13'h1FFF;
    localparam logic [ADDR_W-1:0] ACC_LOAD_A_ADDR = 13'h0001;
    localparam logic [ADDR_W-1:0] ACC_LOAD_X_ADDR = 13'h0002;

    localparam logic [1:0] A_FULL       = 2'(A_WORDS);
    localparam logic [7:0] X_FULL       = 8'(X_WORDS);
    localparam logic [9:0] RES_LAST_IDX = 10'(RES_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS_W = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DONE  = 2'd3
    } acc_state_e;

endpackage

// File: rtl/acc_apb_if.sv
// APB3 bus bundle between the system bus and the accelerator slave.
interface acc_apb_if;
    import acc_pkg::*;

    // A transfer completes on the cycle with PSEL & PENABLE & PREADY; PRDATA
    // and PSLVERR carry meaning only on that cycle and are 0 otherwise.
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/acc_load_ctr.sv
// Filter/image word counters; fires start once a full image lands on a full filter.
module acc_load_ctr
    import acc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       a_inc,
    input  logic       x_inc,
    output logic [1:0] a_cnt,
    output logic [7:0] x_cnt,
    output logic       a_full,
    output logic       start
);

    logic x_wrap;

    assign a_full = (a_cnt == A_FULL);
    // x_cnt sits at X_WORDS for exactly one cycle; that cycle is the start slot.
    assign x_wrap = (x_cnt == X_FULL);
    assign start  = x_wrap & a_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt <= 2'd0;
            x_cnt <= 8'd0;
        end else if (clr) begin
            a_cnt <= 2'd0;
            x_cnt <= 8'd0;
        end else if (x_wrap) begin
            x_cnt <= 8'd0;
            if (a_full) a_cnt <= 2'd0;
        end else begin
            if (x_inc) x_cnt <= x_cnt + 8'd1;
            if (a_inc) a_cnt <= a_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/acc_apb_slave.sv
// APB3 slave front end of the conv accelerator: steers buffer loads, drives the
// clock-gate enable and start pulse, and serves result reads with one wait state.
module acc_apb_slave
    import acc_pkg::*;
(
    input  logic             HCLK,
    input  logic             HRESETn,
    acc_apb_if.slave         apb,
    output logic             acc_en,
    output logic             a_we,
    output logic [1:0]       a_waddr,
    output logic             x_we,
    output logic [7:0]       x_waddr,
    output logic [31:0]      wdata,
    output logic             start,
    input  logic             busy,
    output logic [9:0]       res_raddr,
    input  logic [RES_W-1:0] res_rdata,
    output acc_state_e       dbg_state
);

    acc_state_e        state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_err_q;
    logic              en_wr;
    logic              cnt_clr;
    logic              a_full;
    logic              setup;
    logic [9:0]        rd_idx;
    logic              rd_ok;

    assign setup     = apb.PSEL & ~apb.PENABLE;
    assign rd_idx    = apb.PADDR[11:2];
    assign rd_ok     = (apb.PADDR[ADDR_W-1:12] == '0) && (apb.PADDR[1:0] == 2'b00) &&
                       (rd_idx != 10'd0) && (rd_idx <= RES_LAST_IDX);
    assign cnt_clr   = en_wr & ~wdata[0];
    assign dbg_state = state;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Address, write data and read index are captured in the setup cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q    <= '0;
            wdata     <= 32'd0;
            res_raddr <= 10'd0;
            rd_err_q  <= 1'b0;
            acc_en    <= 1'b0;
        end else begin
            if (state == IDLE && setup) begin
                addr_q <= apb.PADDR;
                if (apb.PWRITE) begin
                    wdata <= apb.PWDATA;
                end else begin
                    res_raddr <= rd_idx - 10'd1;
                    rd_err_q  <= ~rd_ok;
                end
            end
            if (en_wr) acc_en <= wdata[0];
        end
    end

    always_comb begin
        state_nxt   = state;
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;
        apb.PRDATA  = 32'd0;
        a_we        = 1'b0;
        x_we        = 1'b0;
        en_wr       = 1'b0;
        case (state)
            IDLE: begin
                if (setup) state_nxt = apb.PWRITE ? ACCESS_W : RD_ISSUE;
            end
            ACCESS_W: begin
                state_nxt = IDLE;
                if (apb.PSEL && apb.PENABLE) begin
                    apb.PREADY = 1'b1;
                    case (addr_q)
                        ACC_EN_ADDR: en_wr = 1'b1;
                        ACC_LOAD_A_ADDR: begin
                            if (!acc_en || busy || a_full) apb.PSLVERR = 1'b1;
                            else                           a_we        = 1'b1;
                        end
                        ACC_LOAD_X_ADDR: begin
                            if (!acc_en || busy) apb.PSLVERR = 1'b1;
                            else                 x_we        = 1'b1;
                        end
                        default: apb.PSLVERR = 1'b1;
                    endcase
                end
            end
            RD_ISSUE: begin
                state_nxt = apb.PSEL ? RD_DONE : IDLE;
            end
            RD_DONE: begin
                state_nxt = IDLE;
                if (apb.PSEL && apb.PENABLE) begin
                    apb.PREADY = 1'b1;
                    if (rd_err_q || busy) apb.PSLVERR = 1'b1;
                    else                  apb.PRDATA  = {{(32-RES_W){1'b0}}, res_rdata};
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    acc_load_ctr u_load_ctr (
        .clk    (HCLK),
        .rst_n  (HRESETn),
        .clr    (cnt_clr),
        .a_inc  (a_we),
        .x_inc  (x_we),
        .a_cnt  (a_waddr),
        .x_cnt  (x_waddr),
        .a_full (a_full),
        .start  (start)
    );

endmodule

// File: tb/tb_acc_apb_slave.sv
// Directed bench for the accelerator APB slave: loads, start pulse, reads, errors, reset.
module tb_acc_apb_slave;
    import acc_pkg::*;

    logic             HCLK = 1'b0;
    logic             HRESETn = 1'b0;
    logic             busy;
    logic             acc_en, a_we, x_we, start;
    logic [1:0]       a_waddr;
    logic [7:0]       x_waddr;
    logic [31:0]      wdata;
    logic [9:0]       res_raddr;
    logic [RES_W-1:0] res_rdata = '0;
    acc_state_e       dbg_state;

    acc_apb_if apb();

    acc_apb_slave dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .apb       (apb.slave),
        .acc_en    (acc_en),
        .a_we      (a_we),
        .a_waddr   (a_waddr),
        .x_we      (x_we),
        .x_waddr   (x_waddr),
        .wdata     (wdata),
        .start     (start),
        .busy      (busy),
        .res_raddr (res_raddr),
        .res_rdata (res_rdata),
        .dbg_state (dbg_state)
    );

    always #5 HCLK = ~HCLK;

    // Result RAM stand-in: entry i holds i+100, one cycle of read latency.
    always @(posedge HCLK) res_rdata <= RES_W'(res_raddr) + RES_W'(100);

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;
    int a_we_cnt = 0;
    int x_we_cnt = 0;
    int err_leak = 0;

    always @(negedge HCLK) begin
        if (start) start_cnt++;
        if (a_we) a_we_cnt++;
        if (x_we) x_we_cnt++;
        if (apb.PSLVERR && !apb.PREADY) err_leak++;
    end

    logic        last_err, last_a, last_x;
    logic [1:0]  last_aaddr;
    logic [7:0]  last_xaddr;
    logic [31:0] last_wd, last_rdata;
    logic [9:0]  last_raddr;
    int          last_waits;

    logic [31:0] a_vec [3] = '{32'h01020304, 32'h05060708, 32'h00000009};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] x_word(input int i);
        return (32'(i) * 32'h01000193) ^ 32'hA5A5_0000;
    endfunction

    // One APB transfer; observations of the completing cycle land in last_*.
    task automatic apb_xfer(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        int waits;
        @(posedge HCLK); #1;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = wr;
        apb.PADDR   = addr;
        apb.PWDATA  = data;
        @(posedge HCLK); #1;
        apb.PENABLE = 1'b1;
        waits = 0;
        @(negedge HCLK);
        last_raddr = res_raddr;
        while (!apb.PREADY && waits < 8) begin
            waits++;
            @(negedge HCLK);
        end
        if (!apb.PREADY) check("xfer_timeout", {31'd0, apb.PREADY}, 32'd1);
        last_err   = apb.PSLVERR;
        last_rdata = apb.PRDATA;
        last_a     = a_we;
        last_aaddr = a_waddr;
        last_x     = x_we;
        last_xaddr = x_waddr;
        last_wd    = wdata;
        last_waits = waits;
        @(posedge HCLK); #1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap_a, snap_x, snap_s;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = 32'd0; busy = 1'b0;
        repeat (3) @(posedge HCLK); #1;

        check("rst_prdata", apb.PRDATA, 32'd0);
        check("rst_pready", apb.PREADY, 32'd0);
        check("rst_pslverr", apb.PSLVERR, 32'd0);
        check("rst_acc_en", acc_en, 32'd0);
        check("rst_a_we", a_we, 32'd0);
        check("rst_x_we", x_we, 32'd0);
        check("rst_start", start, 32'd0);
        check("rst_a_cnt", a_waddr, 32'd0);
        check("rst_x_cnt", x_waddr, 32'd0);
        check("rst_state", dbg_state, IDLE);
        HRESETn = 1'b1;

        apb_xfer(1'b1, ACC_LOAD_A_ADDR, 32'h11);
        check("a_dis_err", last_err, 32'd1);
        check("a_dis_we", last_a, 32'd0);
        check("a_dis_cnt", a_waddr, 32'd0);

        apb_xfer(1'b1, ACC_EN_ADDR, 32'd1);
        check("en_err", last_err, 32'd0);
        check("en_val", acc_en, 32'd1);
        check("wr_waits", last_waits, 32'd0);

        for (int i = 0; i < 3; i++) begin
            apb_xfer(1'b1, ACC_LOAD_A_ADDR, a_vec[i]);
            check("a_err", last_err, 32'd0);
            check("a_we", last_a, 32'd1);
            check("a_addr", last_aaddr, 32'(i));
            check("a_data", last_wd, a_vec[i]);
        end
        check("a_cnt_full", a_waddr, 32'd3);

        apb_xfer(1'b1, ACC_LOAD_A_ADDR, 32'hDEAD);
        check("a_sat_err", last_err, 32'd1);
        check("a_sat_we", last_a, 32'd0);
        check("a_sat_cnt", a_waddr, 32'd3);

        busy = 1'b1;
        apb_xfer(1'b1, ACC_LOAD_X_ADDR, 32'h55);
        busy = 1'b0;
        check("x_busy_err", last_err, 32'd1);
        check("x_busy_we", last_x, 32'd0);
        check("x_busy_cnt", x_waddr, 32'd0);

        for (int i = 0; i < X_WORDS; i++) begin
            apb_xfer(1'b1, ACC_LOAD_X_ADDR, x_word(i));
            check("x_err", last_err, 32'd0);
            check("x_we", last_x, 32'd1);
            check("x_addr", last_xaddr, 32'(i));
            check("x_data", last_wd, x_word(i));
            if (i == X_WORDS - 2) check("no_early_start", start_cnt, 32'd0);
        end
        check("start_now", start, 32'd1);
        @(posedge HCLK); #1;
        check("start_cnt", start_cnt, 32'd1);
        check("start_low", start, 32'd0);
        check("a_cnt_clr", a_waddr, 32'd0);
        check("x_cnt_clr", x_waddr, 32'd0);
        check("a_we_total", a_we_cnt, 32'd3);
        check("x_we_total", x_we_cnt, 32'd196);

        apb_xfer(1'b0, 13'd4, 32'd0);
        check("rd4_err", last_err, 32'd0);
        check("rd4_raddr", last_raddr, 32'd0);
        check("rd4_waits", last_waits, 32'd1);
        check("rd4_data", last_rdata, 32'd100);
        apb_xfer(1'b0, 13'd3136, 32'd0);
        check("rd_last_err", last_err, 32'd0);
        check("rd_last_data", last_rdata, 32'd883);
        apb_xfer(1'b0, 13'd0, 32'd0);
        check("rd0_err", last_err, 32'd1);
        check("rd0_data", last_rdata, 32'd0);
        apb_xfer(1'b0, 13'd3140, 32'd0);
        check("rd_over_err", last_err, 32'd1);
        check("rd_over_data", last_rdata, 32'd0);
        apb_xfer(1'b0, ACC_EN_ADDR, 32'd0);
        check("rd_undec_err", last_err, 32'd1);
        check("rd_undec_data", last_rdata, 32'd0);
        busy = 1'b1;
        apb_xfer(1'b0, 13'd8, 32'd0);
        busy = 1'b0;
        check("rd_busy_err", last_err, 32'd1);
        check("rd_busy_data", last_rdata, 32'd0);
        check("rd_busy_waits", last_waits, 32'd1);
        apb_xfer(1'b1, 13'h0010, 32'h1234);
        check("wr_undec_err", last_err, 32'd1);
        check("wr_undec_a", last_a, 32'd0);
        check("wr_undec_x", last_x, 32'd0);

        for (int i = 0; i < 3; i++) apb_xfer(1'b1, ACC_LOAD_A_ADDR, a_vec[i]);
        for (int i = 0; i < 99; i++) apb_xfer(1'b1, ACC_LOAD_X_ADDR, x_word(i));
        @(posedge HCLK); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = ACC_LOAD_X_ADDR; apb.PWDATA = x_word(99);
        @(posedge HCLK); #1;
        apb.PENABLE = 1'b1;
        #1;
        check("pre_rst_x_we", x_we, 32'd1);
        check("pre_rst_x_addr", x_waddr, 32'd99);
        HRESETn = 1'b0;
        #1;
        check("mid_rst_x_we", x_we, 32'd0);
        check("mid_rst_pready", apb.PREADY, 32'd0);
        check("mid_rst_pslverr", apb.PSLVERR, 32'd0);
        check("mid_rst_acc_en", acc_en, 32'd0);
        check("mid_rst_a_cnt", a_waddr, 32'd0);
        check("mid_rst_x_cnt", x_waddr, 32'd0);
        check("mid_rst_wdata", wdata, 32'd0);
        check("mid_rst_state", dbg_state, IDLE);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        snap_a = a_we_cnt; snap_x = x_we_cnt; snap_s = start_cnt;
        repeat (5) @(posedge HCLK); #1;
        check("post_rst_a_we", a_we_cnt - snap_a, 32'd0);
        check("post_rst_x_we", x_we_cnt - snap_x, 32'd0);
        check("post_rst_start", start_cnt - snap_s, 32'd0);

        apb_xfer(1'b1, ACC_EN_ADDR, 32'd1);
        snap_s = start_cnt;
        for (int i = 0; i < 3; i++) begin
            apb_xfer(1'b1, ACC_LOAD_A_ADDR, a_vec[i]);
            check("reload_a_addr", last_aaddr, 32'(i));
        end
        for (int i = 0; i < X_WORDS; i++) begin
            apb_xfer(1'b1, ACC_LOAD_X_ADDR, x_word(i));
            check("reload_x_addr", last_xaddr, 32'(i));
        end
        @(posedge HCLK); #1;
        check("reload_start", start_cnt - snap_s, 32'd1);
        check("reload_x_cnt", x_waddr, 32'd0);
        check("pslverr_qualified", err_leak, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/acc_apb_slave.md
Name: acc_apb_slave

Overview:
APB3 slave front end of the convolution accelerator. It decodes PADDR and steers packed 32-bit words into the filter (A) buffer and the image (X) buffer. It generates the compute-start pulse and clock-gate enable, and serves result reads from the result RAM, inserting one wait state per read. It sits between the system APB bus and the conv datapath inside acc_top.

Parameters:
ADDR_W, 13, APB address width
A_WORDS, 3, words per 3x3 filter (8 bits per tap; the last word carries one tap in bits [7:0])
X_WORDS, 196, words per 28x28 image (4 pixels per word)
RES_DEPTH, 784, result RAM entries
RES_W, 20, result width

Ports:
HCLK  in  1  clock
HRESETn  in  1  async active-low reset
PADDR  in  ADDR_W  APB address
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  APB direction
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data
PREADY  out  1  APB ready
PSLVERR  out  1  APB error
acc_en  out  1  clock-gate enable to datapath
a_we  out  1  A buffer write strobe
a_waddr  out  2  A buffer word address
x_we  out  1  X buffer write strobe
x_waddr  out  8  X buffer word address
wdata  out  32  shared buffer write data (PWDATA registered)
start  out  1  one-cycle compute start pulse
busy  in  1  datapath computing
res_raddr  out  10  result RAM read address
res_rdata  in  RES_W  result RAM data, valid 1 cycle after address

Behaviour:
- Single clock HCLK; asynchronous active-low reset HRESETn.
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, acc_en=0, a_we=0, x_we=0, start=0, all address counters=0, FSM=IDLE.
- Address map:
  - 0x1FFF: ENABLE. acc_en <= PWDATA[0]. Writing 0 also clears the A and X counters.
  - 0x0001: LOAD_A. Write to A buffer at a_cnt, then a_cnt++.
  - 0x0002: LOAD_X. Write to X buffer at x_cnt, then x_cnt++.
  - Reads at 4*i, 1<=i<=RES_DEPTH: return {12'b0, result[i-1]}.
- FSM states: IDLE, ACCESS_W, RD_ISSUE, RD_DONE.
  - IDLE, PSEL&!PENABLE&PWRITE -> ACCESS_W.
  - IDLE, PSEL&!PENABLE&!PWRITE -> RD_ISSUE. res_raddr = PADDR[11:2]-1 is registered.
  - ACCESS_W: PREADY=1 for one cycle. Exactly one a_we/x_we pulse with wdata=PWDATA. Then -> IDLE.
  - RD_ISSUE: PREADY=0 (one wait state) -> RD_DONE.
  - RD_DONE: PRDATA={12'b0,res_rdata}, PREADY=1 -> IDLE.
  - Read latency: setup cycle + 2 access cycles.
- PREADY is deasserted in every state other than ACCESS_W and RD_DONE.
- start pulse: asserted one cycle after the write that takes x_cnt from X_WORDS-1 to X_WORDS, only if a_cnt==A_WORDS.
  - On start, both counters reset to 0 so the next filter/image pair loads from index 0.
  - If A is incomplete at that point, x_cnt still wraps to 0 and no start is issued.
- Counter saturation:
  - A write with a_cnt==A_WORDS: no a_we, PSLVERR=1, PREADY=1.
  - x_cnt only reaches X_WORDS transiently (cleared on the next cycle), so it never saturates.
- busy=1 or acc_en=0 during LOAD_A/LOAD_X: write dropped (no strobe, counter held), PSLVERR=1 with PREADY.
- busy=1 during a result read: PSLVERR=1 and PRDATA=0, still with the one-cycle wait.
- Error cases, each answered with PSLVERR=1 and PRDATA=0 on the completing cycle:
  - read of an undecoded address;
  - read index 0 or index > RES_DEPTH;
  - write to an undecoded address.
- PSLVERR is valid only while PREADY=1; otherwise 0.
- PSEL drop mid-transfer: FSM returns to IDLE; no strobe issued if not yet in ACCESS_W.
- Reset mid-operation: all state cleared asynchronously; no strobe or start is emitted after reset release.

Decomposition:
- Shared package acc_pkg holds:
  - address constants ACC_EN_ADDR=13'h1FFF, ACC_LOAD_A_ADDR=1, ACC_LOAD_X_ADDR=2;
  - A_WORDS, X_WORDS, RES_DEPTH, RES_W;
  - FSM state typedef.
- One natural sub-module, acc_load_ctr: the A/X word counters plus start-pulse logic.
- The APB FSM and decode stay in the top module.

Test Plan:
- Write 0x1FFF=1, then LOAD_A 3 words (0x01020304, 0x05060708, 0x00000009) -> a_we pulses at a_waddr 0,1,2 with matching wdata; PSLVERR=0.
- Continue with 196 LOAD_X words -> x_waddr 0..195. Exactly one start pulse, one cycle after the 196th write; counters then 0.
- res_rdata model returns addr+100. Read PADDR=4 -> res_raddr=0, one wait state, PRDATA=100. Read PADDR=3136 -> PRDATA=883.
- LOAD_A with acc_en=0 -> no a_we, PSLVERR=1. A 4th LOAD_A after 3 valid writes -> PSLVERR=1, a_cnt stays 3.
- Read PADDR=0 and PADDR=3140 -> PSLVERR=1, PRDATA=0. busy=1 during a LOAD_X -> PSLVERR=1, x_cnt unchanged.
- Assert HRESETn low during the 100th X write -> all outputs 0 immediately. Reload both buffers -> addresses restart at 0 and start fires once.
